// File: rtl/execute_cycle_if.sv
// execute_cycle_if: ID/EX inputs and EX/MEM outputs of the EX stage
//   master: pipeline side driving ID/EX fields and observing EX/MEM
//   slave:  the EX stage itself
interface execute_cycle_if;
  logic        RegWriteE, MemReadE, memtoRegE, MemWriteE, BranchE, ALUSrcE, MulE, FlushE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, InstrE, ResultW;
  logic        busy_o;
  logic        RegWriteM, MemReadM, memtoRegM, MemWriteM, BranchM, ZeroM;
  logic [31:0] ALUOutM, ReadData2M, InstrM, PCTargetM;
  modport master (
    output RegWriteE, MemReadE, memtoRegE, MemWriteE, BranchE, ALUSrcE, MulE, FlushE,
           ALUControlE, ForwardAE, ForwardBE, RD1E, RD2E, ImmExtE, PCE, InstrE, ResultW,
    input  busy_o, RegWriteM, MemReadM, memtoRegM, MemWriteM, BranchM, ZeroM,
           ALUOutM, ReadData2M, InstrM, PCTargetM
  );
  modport slave (
    input  RegWriteE, MemReadE, memtoRegE, MemWriteE, BranchE, ALUSrcE, MulE, FlushE,
           ALUControlE, ForwardAE, ForwardBE, RD1E, RD2E, ImmExtE, PCE, InstrE, ResultW,
    output busy_o, RegWriteM, MemReadM, memtoRegM, MemWriteM, BranchM, ZeroM,
           ALUOutM, ReadData2M, InstrM, PCTargetM
  );
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle: RV32 EX stage with forwarding, ALU, branch target, iterative MUL and EX/MEM register
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  ID/EX inputs, busy_o stall request, EX/MEM register outputs
module execute_cycle #(
  parameter int MUL_ITER = 32
) (
  input logic clk,
  input logic rst,
  execute_cycle_if.slave bus
);
  localparam int CW = $clog2(MUL_ITER + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [31:0] srcA, fwdB, srcB, aluRes, res, mcand, mplier, acc;
  logic [CW-1:0] cnt;
  logic capture;
  function automatic logic [31:0] fwd(input logic [31:0] rd, input logic [1:0] sel,
                                      input logic [31:0] w, input logic [31:0] m);
    return sel == 2'b01 ? w : sel == 2'b10 ? m : rd;
  endfunction
  assign srcA = fwd(bus.RD1E, bus.ForwardAE, bus.ResultW, bus.ALUOutM);
  assign fwdB = fwd(bus.RD2E, bus.ForwardBE, bus.ResultW, bus.ALUOutM);
  assign srcB = bus.ALUSrcE ? bus.ImmExtE : fwdB;
  always_comb begin
    aluRes = '0;
    case (bus.ALUControlE)
      4'd0: aluRes = srcA + srcB;
      4'd1: aluRes = srcA - srcB;
      4'd2: aluRes = srcA & srcB;
      4'd3: aluRes = srcA | srcB;
      4'd4: aluRes = srcA ^ srcB;
      4'd5: aluRes = srcA << srcB[4:0];
      4'd6: aluRes = srcA >> srcB[4:0];
      4'd7: aluRes = $signed(srcA) >>> srcB[4:0];
      4'd8: aluRes = {31'b0, $signed(srcA) < $signed(srcB)};
      4'd9: aluRes = {31'b0, srcA < srcB};
      default: aluRes = '0;
    endcase
  end
  assign res = state == DONE ? acc : aluRes;
  // EX/MEM takes a real instruction only from a plain IDLE op or a finished MUL; everything else is a bubble
  assign capture = !bus.FlushE && (state == DONE || (state == IDLE && !bus.MulE));
  assign bus.busy_o = !bus.FlushE && (state == BUSY || (state == IDLE && bus.MulE));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      {bus.RegWriteM, bus.MemReadM, bus.memtoRegM, bus.MemWriteM, bus.BranchM, bus.ZeroM} <= '0;
      bus.ALUOutM <= '0;
      bus.ReadData2M <= '0;
      bus.InstrM <= '0;
      bus.PCTargetM <= '0;
    end else begin
      {bus.RegWriteM, bus.MemReadM, bus.memtoRegM, bus.MemWriteM, bus.BranchM} <= capture ?
        {bus.RegWriteE, bus.MemReadE, bus.memtoRegE, bus.MemWriteE, bus.BranchE} : 5'b0;
      bus.ZeroM <= capture && res == '0;
      bus.InstrM <= capture ? bus.InstrE : '0;
      if (capture) begin
        bus.ALUOutM <= res;
        bus.ReadData2M <= fwdB;
        bus.PCTargetM <= bus.PCE + bus.ImmExtE;
      end
      // Operands are latched on entry because forwarding sources move while IF/ID is stalled
      if (bus.FlushE) state <= IDLE;
      else if (state == IDLE && bus.MulE) begin
        state <= BUSY;
        mcand <= srcA;
        mplier <= srcB;
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= acc + (mplier[0] ? mcand : 32'd0);
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(MUL_ITER - 1)) state <= DONE;
      end else if (state == DONE) state <= IDLE;
    end
  end
endmodule
